// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multi-cycle MIPS-style datapath.
//
// The state register and the memory wait counter are the only storage.
// Control outputs are decoded from the current state. A few strobes are also
// qualified by live inputs: ir_write/pc_write in FETCH wait for mem_ready,
// pc_write in BRANCH depends on zero, and pc_write in R_EXEC depends on funct
// for jr. Because of this the outputs cannot be registered without adding a
// cycle of latency. The `state` port exposes the current state for debug.
//
// Handshake: a memory access in FETCH, MEM_READ or MEM_WRITE completes in the
// cycle where mem_ready=1. The request (mem_read/mem_write) is held until that
// cycle. If mem_ready stays low for MEM_TIMEOUT consecutive cycles, the FSM
// moves to ERROR and stays there until reset.
//
// Build option: define JAL_SUPPORT_EN to enable the JAL state. Without it,
// opcode 000011 decodes as illegal.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       alu_src_a,
  output logic       mem_to_reg,
  output logic [1:0] reg_dst,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       error
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JAL       = 4'd12,
    S_LUI       = 4'd13,
    S_ERROR     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Counter value at which one more idle cycle means the timeout is reached.
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        waiting;
  logic        timeout;
  logic [4:0]  strobe_c;   // {pc_write, ir_write, reg_write, mem_read, mem_write}

  // Next-state selection and memory wait counter update.
  always_comb begin
    waiting = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
               (state_q == S_MEM_WRITE)) && !mem_ready;
    timeout = waiting && (wait_q == WAIT_LAST);
    wait_d  = (waiting && !timeout) ? wait_q + 16'd1 : 16'd0;
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:        state_d = S_R_EXEC;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_ADDI, OP_ORI: state_d = S_I_EXEC;
          OP_J:            state_d = S_JUMP;
`ifdef JAL_SUPPORT_EN
          OP_JAL:          state_d = S_JAL;
`endif
          OP_LUI:          state_d = S_LUI;
          default:         state_d = S_ERROR;
        endcase
      end
      S_R_EXEC:    state_d = (funct == FN_JR) ? S_FETCH : S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_MEM_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_LUI:       state_d = S_FETCH;
`ifdef JAL_SUPPORT_EN
      S_JAL:       state_d = S_FETCH;
`endif
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_ERROR;
    endcase
    if (timeout) state_d = S_ERROR;
  end

  // State and wait counter registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Moore decode of control outputs; anything not named for a state is 0.
  always_comb begin
    strobe_c   = 5'b00000;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 2'b00;
    pc_source  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    error      = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        strobe_c  = {mem_ready, mem_ready, 1'b0, 1'b1, 1'b0};
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        if (funct == FN_JR) begin
          pc_source = 2'b11;
          strobe_c  = 5'b10000;
        end
      end
      S_R_WB: begin
        reg_dst  = 2'b01;
        strobe_c = 5'b00100;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        iord     = 1'b1;
        strobe_c = 5'b00010;
      end
      S_MEM_WRITE: begin
        iord     = 1'b1;
        strobe_c = 5'b00001;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        strobe_c   = 5'b00100;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_source = 2'b01;
        strobe_c  = {((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero),
                     4'b0000};
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ORI) ? 3'b011 : 3'b000;
      end
      S_I_WB:      strobe_c = 5'b00100;
      S_JUMP: begin
        pc_source = 2'b10;
        strobe_c  = 5'b10000;
      end
      S_LUI:       strobe_c = 5'b00100;
`ifdef JAL_SUPPORT_EN
      S_JAL: begin
        reg_dst   = 2'b10;
        pc_source = 2'b10;
        strobe_c  = 5'b10100;
      end
`endif
      S_ERROR:     error = 1'b1;
      default:     ;
    endcase
  end

  // Strobes are forced low for as long as reset is held, whatever the state.
  assign {pc_write, ir_write, reg_write, mem_read, mem_write} =
    reset ? strobe_c : 5'b00000;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven bench for multicycle_control built with
// MEM_TIMEOUT=4. Each row gives one cycle of inputs plus the full expected
// output vector, packed as
// {state, error, pc_write, ir_write, reg_write, mem_read, mem_write,
//  iord, alu_src_a, mem_to_reg, reg_dst, pc_source, alu_src_b, alu_op}.
module tb_multicycle_control;

  localparam int W = 22;

  logic       clk;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write;
  logic       iord, alu_src_a, mem_to_reg;
  logic [1:0] reg_dst, pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       error;

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .alu_src_a(alu_src_a), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .pc_source(pc_source), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .error(error)
  );

  // Expected vectors:  state  err  pc,ir,rw,mr,mw  iord,asa,m2r  rdst psrc asb  aop
  localparam logic [W-1:0] E_RST   = {4'd0,  1'b0, 5'b00000, 3'b000, 2'b00, 2'b00, 2'b01, 3'b000};
  localparam logic [W-1:0] E_FETCH = {4'd0,  1'b0, 5'b11010, 3'b000, 2'b00, 2'b00, 2'b01, 3'b000};
  localparam logic [W-1:0] E_FWAIT = {4'd0,  1'b0, 5'b00010, 3'b000, 2'b00, 2'b00, 2'b01, 3'b000};
  localparam logic [W-1:0] E_DEC   = {4'd1,  1'b0, 5'b00000, 3'b000, 2'b00, 2'b00, 2'b11, 3'b000};
  localparam logic [W-1:0] E_MADDR = {4'd2,  1'b0, 5'b00000, 3'b010, 2'b00, 2'b00, 2'b10, 3'b000};
  localparam logic [W-1:0] E_MRD   = {4'd3,  1'b0, 5'b00010, 3'b100, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [W-1:0] E_MWB   = {4'd4,  1'b0, 5'b00100, 3'b001, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [W-1:0] E_MWR   = {4'd5,  1'b0, 5'b00001, 3'b100, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [W-1:0] E_REX   = {4'd6,  1'b0, 5'b00000, 3'b010, 2'b00, 2'b00, 2'b00, 3'b010};
  localparam logic [W-1:0] E_JR    = {4'd6,  1'b0, 5'b10000, 3'b010, 2'b00, 2'b11, 2'b00, 3'b010};
  localparam logic [W-1:0] E_RWB   = {4'd7,  1'b0, 5'b00100, 3'b000, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [W-1:0] E_BR1   = {4'd8,  1'b0, 5'b10000, 3'b010, 2'b00, 2'b01, 2'b00, 3'b001};
  localparam logic [W-1:0] E_BR0   = {4'd8,  1'b0, 5'b00000, 3'b010, 2'b00, 2'b01, 2'b00, 3'b001};
  localparam logic [W-1:0] E_JMP   = {4'd9,  1'b0, 5'b10000, 3'b000, 2'b00, 2'b10, 2'b00, 3'b000};
  localparam logic [W-1:0] E_ADDI  = {4'd10, 1'b0, 5'b00000, 3'b010, 2'b00, 2'b00, 2'b10, 3'b000};
  localparam logic [W-1:0] E_ORI   = {4'd10, 1'b0, 5'b00000, 3'b010, 2'b00, 2'b00, 2'b10, 3'b011};
  localparam logic [W-1:0] E_IWB   = {4'd11, 1'b0, 5'b00100, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [W-1:0] E_JAL   = {4'd12, 1'b0, 5'b10100, 3'b000, 2'b10, 2'b10, 2'b00, 3'b000};
  localparam logic [W-1:0] E_LUI   = {4'd13, 1'b0, 5'b00100, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [W-1:0] E_ERR   = {4'd15, 1'b1, 5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000};

  typedef struct {
    logic [5:0]   op;
    logic [5:0]   fn;
    logic         z;
    logic         mr;
    logic [W-1:0] exp;
  } vec_t;

  vec_t           tbl[$];
  logic [W-1:0]   exp_q[$];
  int             checks;
  int             failures;

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] dut_vec();
    return {state, error, pc_write, ir_write, reg_write, mem_read, mem_write,
            iord, alu_src_a, mem_to_reg, reg_dst, pc_source, alu_src_b, alu_op};
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic mr, input logic [W-1:0] exp);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Scoreboard: pop the oldest expectation and compare with the DUT outputs.
  task automatic chk(input string name);
    logic [W-1:0] e;
    logic [W-1:0] got;
    got = dut_vec();
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty got=%h", name, got);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", name, got, e);
      end
    end
  endtask

  // Driver: called at posedge+1; drives one cycle, checks at negedge.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic mr, input logic [W-1:0] exp, input string name);
    opcode = op; funct = fn; zero = z; mem_ready = mr;
    exp_q.push_back(exp);
    @(negedge clk);
    chk(name);
    @(posedge clk);
    #1;
  endtask

  // Assert reset (async check right away), hold one cycle, release at posedge+1.
  task automatic do_reset(input string name);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    exp_q.push_back(E_RST);
    chk({name, "_async"});
    exp_q.push_back(E_RST);
    @(negedge clk);
    chk({name, "_hold"});
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

    // add: FETCH, DECODE, R_EXEC, R_WB
    add(6'h00, 6'h20, 1'b0, 1'b1, E_FETCH);
    add(6'h00, 6'h20, 1'b0, 1'b1, E_DEC);
    add(6'h00, 6'h20, 1'b0, 1'b1, E_REX);
    add(6'h00, 6'h20, 1'b0, 1'b1, E_RWB);
    // jr: R_EXEC returns straight to FETCH
    add(6'h00, 6'h08, 1'b0, 1'b1, E_FETCH);
    add(6'h00, 6'h08, 1'b0, 1'b1, E_DEC);
    add(6'h00, 6'h08, 1'b0, 1'b1, E_JR);
    // lw: fetch waits twice, MEM_READ waits three cycles (held 4 cycles)
    add(6'h23, rnd6(), 1'b0, 1'b0, E_FWAIT);
    add(6'h23, rnd6(), 1'b1, 1'b0, E_FWAIT);
    add(6'h23, rnd6(), 1'b0, 1'b1, E_FETCH);
    add(6'h23, rnd6(), 1'b0, 1'b1, E_DEC);
    add(6'h23, rnd6(), 1'b0, 1'b1, E_MADDR);
    add(6'h23, rnd6(), 1'b0, 1'b0, E_MRD);
    add(6'h23, rnd6(), 1'b0, 1'b0, E_MRD);
    add(6'h23, rnd6(), 1'b0, 1'b0, E_MRD);
    add(6'h23, rnd6(), 1'b0, 1'b1, E_MRD);
    add(6'h23, rnd6(), 1'b0, 1'b1, E_MWB);
    // sw
    add(6'h2b, rnd6(), 1'b0, 1'b1, E_FETCH);
    add(6'h2b, rnd6(), 1'b0, 1'b1, E_DEC);
    add(6'h2b, rnd6(), 1'b0, 1'b1, E_MADDR);
    add(6'h2b, rnd6(), 1'b0, 1'b1, E_MWR);
    // beq zero=1 taken, bne zero=1 not taken, bne zero=0 taken
    add(6'h04, rnd6(), 1'b1, 1'b1, E_FETCH);
    add(6'h04, rnd6(), 1'b1, 1'b1, E_DEC);
    add(6'h04, rnd6(), 1'b1, 1'b1, E_BR1);
    add(6'h05, rnd6(), 1'b1, 1'b1, E_FETCH);
    add(6'h05, rnd6(), 1'b1, 1'b1, E_DEC);
    add(6'h05, rnd6(), 1'b1, 1'b1, E_BR0);
    add(6'h05, rnd6(), 1'b0, 1'b1, E_FETCH);
    add(6'h05, rnd6(), 1'b0, 1'b1, E_DEC);
    add(6'h05, rnd6(), 1'b0, 1'b1, E_BR1);
    // addi, ori
    add(6'h08, rnd6(), 1'b0, 1'b1, E_FETCH);
    add(6'h08, rnd6(), 1'b0, 1'b1, E_DEC);
    add(6'h08, rnd6(), 1'b0, 1'b1, E_ADDI);
    add(6'h08, rnd6(), 1'b0, 1'b1, E_IWB);
    add(6'h0d, rnd6(), 1'b0, 1'b1, E_FETCH);
    add(6'h0d, rnd6(), 1'b0, 1'b1, E_DEC);
    add(6'h0d, rnd6(), 1'b0, 1'b1, E_ORI);
    add(6'h0d, rnd6(), 1'b0, 1'b1, E_IWB);
    // j after three fetch waits (one short of the timeout)
    add(6'h02, rnd6(), 1'b0, 1'b0, E_FWAIT);
    add(6'h02, rnd6(), 1'b0, 1'b0, E_FWAIT);
    add(6'h02, rnd6(), 1'b0, 1'b0, E_FWAIT);
    add(6'h02, rnd6(), 1'b0, 1'b1, E_FETCH);
    add(6'h02, rnd6(), 1'b0, 1'b1, E_DEC);
    add(6'h02, rnd6(), 1'b0, 1'b1, E_JMP);
    // lui
    add(6'h0f, rnd6(), 1'b0, 1'b1, E_FETCH);
    add(6'h0f, rnd6(), 1'b0, 1'b1, E_DEC);
    add(6'h0f, rnd6(), 1'b0, 1'b1, E_LUI);
    // jal
    add(6'h03, rnd6(), 1'b0, 1'b1, E_FETCH);
    add(6'h03, rnd6(), 1'b0, 1'b1, E_DEC);
`ifdef JAL_SUPPORT_EN
    add(6'h03, rnd6(), 1'b0, 1'b1, E_JAL);
    add(6'h00, 6'h20, 1'b0, 1'b1, E_FETCH);
`else
    add(6'h03, rnd6(), 1'b0, 1'b1, E_ERR);
    add(6'h00, 6'h20, 1'b0, 1'b1, E_ERR);
`endif

    @(posedge clk);
    #1;
    do_reset("rst0");
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].mr, tbl[i].exp, $sformatf("vec%0d", i));

    // Fetch timeout: four idle cycles, then ERROR sticks even with mem_ready=1.
    do_reset("rst1");
    for (int i = 0; i < 4; i++)
      step(6'h00, rnd6(), 1'b0, 1'b0, E_FWAIT, $sformatf("fto_wait%0d", i));
    for (int i = 0; i < 3; i++)
      step(rnd6(), rnd6(), 1'b0, 1'b1, E_ERR, $sformatf("fto_err%0d", i));

    // Illegal opcode goes to ERROR and stays.
    do_reset("rst2");
    step(6'h3f, rnd6(), 1'b0, 1'b1, E_FETCH, "ill_fetch");
    step(6'h3f, rnd6(), 1'b0, 1'b1, E_DEC, "ill_dec");
    step(6'h3f, rnd6(), 1'b0, 1'b1, E_ERR, "ill_err0");
    step(6'h00, rnd6(), 1'b0, 1'b1, E_ERR, "ill_err1");

    // MEM_READ timeout after four idle cycles.
    do_reset("rst3");
    step(6'h23, rnd6(), 1'b0, 1'b1, E_FETCH, "mto_fetch");
    step(6'h23, rnd6(), 1'b0, 1'b1, E_DEC, "mto_dec");
    step(6'h23, rnd6(), 1'b0, 1'b1, E_MADDR, "mto_addr");
    for (int i = 0; i < 4; i++)
      step(6'h23, rnd6(), 1'b0, 1'b0, E_MRD, $sformatf("mto_wait%0d", i));
    step(6'h23, rnd6(), 1'b0, 1'b1, E_ERR, "mto_err");

    // Reset in the middle of MEM_WRITE drops mem_write without a clock edge.
    do_reset("rst4");
    step(6'h2b, rnd6(), 1'b0, 1'b1, E_FETCH, "arst_fetch");
    step(6'h2b, rnd6(), 1'b0, 1'b1, E_DEC, "arst_dec");
    step(6'h2b, rnd6(), 1'b0, 1'b1, E_MADDR, "arst_addr");
    step(6'h2b, rnd6(), 1'b0, 1'b0, E_MWR, "arst_mw0");
    mem_ready = 1'b0;
    #1;
    exp_q.push_back(E_MWR);
    chk("arst_mw1");
    reset = 1'b0;
    #1;
    exp_q.push_back(E_RST);
    chk("arst_drop");
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(6'h00, 6'h20, 1'b0, 1'b1, E_FETCH, "arst_refetch");
    step(6'h00, 6'h20, 1'b0, 1'b1, E_DEC, "arst_redec");

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, maximum consecutive cycles spent waiting on mem_ready before entering ERROR (1..65535).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 Port: funct  input  6  instruction[5:0] from the instruction register.
REQ-006 Port: zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-007 Port: mem_ready  input  1  memory access complete this cycle.
REQ-008 Port: pc_write, ir_write, reg_write, mem_read, mem_write  output  1 each  strobes.
REQ-009 Port: iord, alu_src_a, mem_to_reg  output  1 each  mux selects. reg_dst, pc_source, alu_src_b  output  2 each  mux selects.
REQ-010 Port: alu_op  output  3  000 add, 001 sub, 010 funct-decoded, 011 or.
REQ-011 Port: state  output  4  current state code. error  output  1  sticky fault flag.

Function
REQ-012 The block SHALL implement a Moore FSM with codes FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JAL=12, LUI=13, ERROR=15.
REQ-013 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00, and SHALL assert ir_write and pc_write only in a cycle with mem_ready=1, then go to DECODE.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=000 and branch on opcode: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100/000101->BRANCH, 001000/001101->I_EXEC, 000010->JUMP, 000011->JAL, 001111->LUI, any other->ERROR.
REQ-015 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010; if funct=001000 (jr) pc_source=11, pc_write=1, next FETCH; else next R_WB.
REQ-016 R_WB: reg_dst=01, mem_to_reg=0, reg_write=1, next FETCH.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; lw->MEM_READ, sw->MEM_WRITE.
REQ-018 MEM_READ/MEM_WRITE: iord=1, mem_read/mem_write=1 respectively; hold state while mem_ready=0; on mem_ready=1 go to MEM_WB (load) or FETCH (store).
REQ-019 MEM_WB: reg_dst=00, mem_to_reg=1, reg_write=1, next FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01; pc_write=1 iff (opcode=000100 and zero=1) or (opcode=000101 and zero=0); next FETCH.
REQ-021 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=000 (addi) or 011 (ori); next I_WB. I_WB: reg_dst=00, reg_write=1, next FETCH.
REQ-022 JUMP: pc_source=10, pc_write=1, next FETCH. LUI: reg_dst=00, mem_to_reg=0, reg_write=1, next FETCH (datapath selects upper-immediate data).
REQ-023 Any signal not listed for a state SHALL be 0.
REQ-024 A wait counter SHALL increment each cycle in FETCH/MEM_READ/MEM_WRITE with mem_ready=0 and clear on mem_ready=1 or state exit; reaching MEM_TIMEOUT SHALL force ERROR next cycle.
REQ-025 ERROR SHALL drive all strobes 0, error=1, and remain until reset.

Reset
REQ-026 While reset=0: state=FETCH, wait counter=0, error=0, and all strobes (pc_write, ir_write, reg_write, mem_read, mem_write) forced 0 regardless of state decode.
REQ-027 Reset asserted mid-instruction SHALL abort it immediately; after release the first cycle SHALL be FETCH outputs.

Configuration
REQ-028 Macro JAL_SUPPORT_EN defined: JAL state drives reg_dst=10 (register 31), mem_to_reg=0, reg_write=1, pc_source=10, pc_write=1, next FETCH (datapath writes PC+4).
REQ-029 Macro JAL_SUPPORT_EN undefined: opcode 000011 SHALL be treated as illegal (DECODE->ERROR) and state code 12 SHALL be unreachable.

Verification
REQ-030 Release reset, mem_ready=1, opcode 000000 funct 100000 -> states 0,1,6,7,0; reg_write=1 only in R_WB, reg_dst=01.
REQ-031 lw (100011) with mem_ready low 3 cycles in MEM_READ -> MEM_READ held exactly 4 cycles, then MEM_WB with mem_to_reg=1, reg_write=1.
REQ-032 beq zero=1 -> pc_write=1 in BRANCH; bne zero=1 -> pc_write=0; both alu_op=001, pc_source=01.
REQ-033 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> state=15, error=1 after 4 waiting cycles; stays until reset=0.
REQ-034 Opcode 111111 in DECODE -> ERROR; jal with JAL_SUPPORT_EN -> reg_dst=10, pc_write=1; without it -> ERROR.
REQ-035 reset driven low during MEM_WRITE -> mem_write drops to 0 asynchronously, state=0 after release.
